word_sync_arb: RTL and testbench

- Round-robin arbiter/sequencer that shares one word-synchronizer channel among P_N_REQ requesters in the source clock domain.
- Captures the winning requester's word and drives the synchronizer's wr strobe and data word.
- Enforces a hold-off window after each launch so the channel's pulse-stretch/sync/handshake completes before the next word.
- Sits directly in front of the word synchronizer's source-side inputs (wr, data_0).

---
 rtl/word_sync_arb_pkg.sv | 18 +
 rtl/word_sync_arb_rr_arbiter.sv | 47 ++++
 rtl/word_sync_arb.sv | 92 +++++++++
 tb/tb_word_sync_arb.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/word_sync_arb_pkg.sv
// Shared definitions for the word-synchronizer arbiter: FSM state encodings
// and a constant-friendly ceiling log2.
package word_sync_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    HOLD   = 2'd2
  } state_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/word_sync_arb_rr_arbiter.sv
// Round-robin selector: a pointer register plus a rotate-priority search that
// picks the first active request at or above the pointer, wrapping around.
module word_sync_arb_rr_arbiter
  import word_sync_arb_pkg::*;
#(
  parameter int P_N_REQ = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [P_N_REQ-1:0]        req,
  input  logic                      advance,
  output logic [clog2(P_N_REQ)-1:0] winner,
  output logic                      valid
);

  localparam int IW = clog2(P_N_REQ);

  logic [IW-1:0] ptr;

  function automatic logic [IW-1:0] rot_idx(input logic [IW-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= P_N_REQ) s = s - P_N_REQ;
    return IW'(s);
  endfunction

  // Scan from the farthest offset down so the nearest active request wins.
  always_comb begin
    winner = ptr;
    valid  = 1'b0;
    for (int i = P_N_REQ - 1; i >= 0; i--) begin
      if (req[rot_idx(ptr, i)]) begin
        winner = rot_idx(ptr, i);
        valid  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (advance && valid) begin
      ptr <= (winner == IW'(P_N_REQ - 1)) ? '0 : winner + 1'b1;
    end
  end

endmodule

// File: rtl/word_sync_arb.sv
// Shares one word-synchronizer channel among several requesters: arbitrates,
// captures the winning word, strobes wr, then holds off until the channel settles.
module word_sync_arb
  import word_sync_arb_pkg::*;
#(
  parameter int P_N_REQ      = 4,
  parameter int P_DATA_WIDTH = 32,
  parameter int P_WR_WIDTH   = 2,
  parameter int P_HOLDOFF    = 16
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [P_N_REQ-1:0]                req,
  input  logic [P_N_REQ*P_DATA_WIDTH-1:0]   data_in,
  output logic [P_N_REQ-1:0]                ack,
  output logic [clog2(P_N_REQ)-1:0]         grant_id,
  output logic                              busy,
  output logic                              wr,
  output logic [P_DATA_WIDTH-1:0]           data_0
);

  localparam int IW      = clog2(P_N_REQ);
  localparam int CNT_MAX = (P_WR_WIDTH > P_HOLDOFF) ? P_WR_WIDTH : P_HOLDOFF;
  localparam int CNT_W   = clog2(CNT_MAX + 1);

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [IW-1:0]     winner;
  logic              valid;
  logic              advance;

  // The pointer only moves on the cycle a launch is actually taken.
  assign advance = (state == IDLE);

  word_sync_arb_rr_arbiter #(
    .P_N_REQ(P_N_REQ)
  ) u_arb (
    .clk    (clk),
    .rst    (rst),
    .req    (req),
    .advance(advance),
    .winner (winner),
    .valid  (valid)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      wr       <= 1'b0;
      ack      <= '0;
      busy     <= 1'b0;
      data_0   <= '0;
      grant_id <= '0;
      cnt      <= '0;
    end else begin
      ack <= '0;
      unique case (state)
        IDLE: begin
          if (valid) begin
            data_0   <= data_in[winner*P_DATA_WIDTH +: P_DATA_WIDTH];
            grant_id <= winner;
            ack      <= P_N_REQ'(1) << winner;
            wr       <= 1'b1;
            busy     <= 1'b1;
            cnt      <= CNT_W'(P_WR_WIDTH - 1);
            state    <= LAUNCH;
          end
        end
        LAUNCH: begin
          if (cnt == '0) begin
            wr    <= 1'b0;
            cnt   <= CNT_W'(P_HOLDOFF - 1);
            state <= HOLD;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        // Hold-off lets the far side finish sync and handshake before the next wr edge.
        HOLD: begin
          if (cnt == '0) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_word_sync_arb.sv
// Scenario bench for word_sync_arb: expected launches are queued as stimulus is
// applied and matched against each ack pulse the arbiter produces.
module tb_word_sync_arb;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int WW = 2;
  localparam int HO = 16;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req;
  logic [N*DW-1:0] data_in;
  logic [N-1:0]    ack;
  logic [1:0]      grant_id;
  logic            busy;
  logic            wr;
  logic [DW-1:0]   data_0;

  typedef struct {
    int          id;
    logic [31:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   passed = 0;

  word_sync_arb #(
    .P_N_REQ(N), .P_DATA_WIDTH(DW), .P_WR_WIDTH(WW), .P_HOLDOFF(HO)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .data_in(data_in), .ack(ack),
    .grant_id(grant_id), .busy(busy), .wr(wr), .data_0(data_0)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every ack pulse must match the oldest queued expectation.
  always @(posedge clk) begin
    #1;
    if (!rst && ack !== '0) begin
      checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL unexpected_ack: ack=%b grant_id=%0d with no launch expected", ack, grant_id);
      end else begin
        exp_t e;
        logic [N-1:0] oh;
        e  = exp_q.pop_front();
        oh = 4'b0001 << e.id;
        if (ack !== oh || grant_id !== 2'(e.id) || data_0 !== e.data || wr !== 1'b1 || busy !== 1'b1)
          $display("FAIL launch: ack=%b grant=%0d data=%h wr=%b busy=%b, expected ack=%b grant=%0d data=%h wr=1 busy=1",
                   ack, grant_id, data_0, wr, busy, oh, e.id, e.data);
        else
          passed++;
      end
    end
  end

  task automatic wait_ack(input int limit, output bit seen, output int n);
    seen = 1'b0;
    n    = 0;
    while (!seen && n < limit) begin
      tick();
      n++;
      if (ack !== '0) seen = 1'b1;
    end
  endtask

  task automatic set_word(input int i, input logic [31:0] w);
    data_in[i*DW +: DW] = w;
  endtask

  task automatic test_reset();
    int bad;
    rst = 1'b1; req = '0; data_in = '0;
    repeat (3) tick();
    checks++; if (wr !== 1'b0) $display("FAIL reset_wr: got %b want 0", wr); else passed++;
    checks++; if (ack !== '0) $display("FAIL reset_ack: got %b want 0000", ack); else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else passed++;
    checks++; if (data_0 !== '0) $display("FAIL reset_data: got %h want 0", data_0); else passed++;
    checks++; if (grant_id !== '0) $display("FAIL reset_grant: got %0d want 0", grant_id); else passed++;
    rst = 1'b0;
    bad = 0;
    repeat (20) begin
      tick();
      if (wr !== 1'b0 || busy !== 1'b0 || ack !== '0) bad++;
    end
    checks++; if (bad != 0) $display("FAIL idle_no_req: %0d active cycles, want 0", bad); else passed++;
  endtask

  task automatic test_single();
    int busy_bad;
    set_word(1, 32'hDEADBEEF);
    req = 4'b0010;
    exp_q.push_back('{1, 32'hDEADBEEF});
    tick();  // edge t
    req = '0;
    checks++; if (ack !== 4'b0010 || wr !== 1'b1) $display("FAIL single_t1: ack=%b wr=%b want 0010/1", ack, wr); else passed++;
    tick();  // t+1
    checks++; if (ack !== '0 || wr !== 1'b1) $display("FAIL single_t2: ack=%b wr=%b want 0000/1", ack, wr); else passed++;
    tick();  // t+2
    checks++; if (wr !== 1'b0 || busy !== 1'b1) $display("FAIL single_wr_fall: wr=%b busy=%b want 0/1", wr, busy); else passed++;
    busy_bad = 0;
    for (int k = 3; k <= 17; k++) begin
      tick();
      if (busy !== 1'b1 || wr !== 1'b0 || data_0 !== 32'hDEADBEEF) busy_bad++;
    end
    checks++; if (busy_bad != 0) $display("FAIL single_hold: %0d bad cycles want 0", busy_bad); else passed++;
    tick();  // t+18
    checks++; if (busy !== 1'b0 || data_0 !== 32'hDEADBEEF || grant_id !== 2'd1)
      $display("FAIL single_end: busy=%b data=%h grant=%0d want 0/deadbeef/1", busy, data_0, grant_id);
    else passed++;
  endtask

  task automatic test_all_four();
    bit seen;
    int n;
    int gap_bad;
    int miss;
    rst = 1'b1; tick(); rst = 1'b0;
    for (int i = 0; i < N; i++) set_word(i, 32'hA0000000 + 32'(i) * 32'h111);
    for (int i = 0; i < 5; i++) exp_q.push_back('{i % N, 32'hA0000000 + 32'(i % N) * 32'h111});
    req = 4'b1111;
    gap_bad = 0; miss = 0;
    for (int l = 0; l < 5; l++) begin
      wait_ack(40, seen, n);
      if (!seen) miss++;
      else if (l > 0 && n != WW + HO + 1) gap_bad++;
    end
    req = '0;
    checks++; if (miss != 0) $display("FAIL all_four_timeout: %0d launches missing", miss); else passed++;
    checks++; if (gap_bad != 0) $display("FAIL all_four_spacing: %0d gaps not %0d cycles", gap_bad, WW + HO + 1); else passed++;
  endtask

  task automatic test_wrap();
    bit seen;
    int n;
    int miss;
    miss = 0;
    // pointer is 1 here; grant 2 moves it to 3
    req = 4'b0100; exp_q.push_back('{2, 32'hA0000222});
    wait_ack(40, seen, n); if (!seen) miss++;
    req = 4'b1001; exp_q.push_back('{3, 32'hA0000333}); exp_q.push_back('{0, 32'hA0000000});
    wait_ack(40, seen, n); if (!seen) miss++;
    req = req & ~ack;
    wait_ack(40, seen, n); if (!seen) miss++;
    req = 4'b0100; exp_q.push_back('{2, 32'hA0000222});
    wait_ack(40, seen, n); if (!seen) miss++;
    req = '0;
    checks++; if (miss != 0) $display("FAIL wrap_timeout: %0d launches missing", miss); else passed++;
  endtask

  task automatic test_reset_mid();
    bit seen;
    int n;
    set_word(1, 32'h11112222);
    req = 4'b0010; exp_q.push_back('{1, 32'h11112222});
    wait_ack(40, seen, n);
    checks++; if (!seen) $display("FAIL reset_mid_launch: no ack within 40 cycles"); else passed++;
    req = 4'b1001;  // pending; pointer would favour 3 without a reset
    tick();         // second LAUNCH cycle
    rst = 1'b1;
    tick();
    checks++; if (wr !== 1'b0 || busy !== 1'b0 || data_0 !== '0 || ack !== '0 || grant_id !== '0)
      $display("FAIL reset_mid: wr=%b busy=%b data=%h ack=%b grant=%0d want all zero", wr, busy, data_0, ack, grant_id);
    else passed++;
    exp_q.push_back('{0, 32'hA0000000});
    exp_q.push_back('{3, 32'hA0000333});
    rst = 1'b0;
    wait_ack(40, seen, n);
    checks++; if (!seen || n != 1) $display("FAIL reset_mid_regrant: seen=%b after %0d cycles want 1/1", seen, n); else passed++;
    req = req & ~ack;
    wait_ack(40, seen, n);
    req = '0;
    checks++; if (!seen) $display("FAIL reset_mid_second: no ack within 40 cycles"); else passed++;
  endtask

  task automatic test_queued();
    bit seen;
    int n;
    int hold_bad;
    int w;
    w = 0;
    while (busy !== 1'b0 && w < 40) begin tick(); w++; end
    req = 4'b0001; exp_q.push_back('{0, 32'hA0000000});
    wait_ack(40, seen, n);
    req = '0;
    checks++; if (!seen) $display("FAIL queued_first: no ack within 40 cycles"); else passed++;
    repeat (5) tick();  // now in HOLD
    set_word(2, 32'hCAFEF00D);
    req = 4'b0100; exp_q.push_back('{2, 32'hCAFEF00D});
    hold_bad = 0;
    n = 5;
    seen = 1'b0;
    while (!seen && n < 40) begin
      tick();
      n++;
      if (ack !== '0) seen = 1'b1;
      else if (data_0 !== 32'hA0000000) hold_bad++;
    end
    req = '0;
    checks++; if (hold_bad != 0) $display("FAIL queued_hold: data_0 changed in %0d cycles", hold_bad); else passed++;
    checks++; if (!seen || n != WW + HO + 1) $display("FAIL queued_timing: ack at +%0d want +%0d", n, WW + HO + 1); else passed++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_all_four();
    test_wrap();
    test_reset_mid();
    test_queued();
    repeat (25) tick();
    checks++; if (exp_q.size() != 0) $display("FAIL scoreboard_drain: %0d launches never seen", exp_q.size()); else passed++;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
